// File: rtl/oclib_async_serial_lanes_to_ready_valid.sv
// -----------------------------------------------------------------------------
// oclib_async_serial_lanes_to_ready_valid
//
// Receives words over Lanes independent 2-wire, 2-phase serial links and
// presents them as a ready/valid stream through a small FIFO.
//
// Each lane owns two wires. Toggling the low wire sends a 0 and toggling the
// high wire sends a 1. The lane answers on its inAck bit. The sender may put
// the next bit on the wires once inAck[l] == ^(lane wires). Word bits are
// spread round-robin across the lanes: lane l, slot k carries word bit
// l+k*Lanes. When MsbFirst is set, that bit index is mirrored.
//
// Ports
//   clock     : single clock
//   resetN    : asynchronous active-low reset
//   inData    : 2*Lanes async wires; lane l uses [2l+1:2l]
//   inAck     : per-lane 2-phase acknowledge
//   outData   : FIFO head word
//   outValid  : FIFO non-empty
//   outReady  : consumer takes the head word when outValid is high
//   outCount  : FIFO occupancy
// -----------------------------------------------------------------------------

// Per-lane receiver. It collects Width/Lanes bits into its own slice of the
// assembly register. The ack for the final slot is held back until the top
// level pushes the complete word. Holding that ack is the only way
// backpressure reaches the sender.
module oclib_async_serial_lanes_to_ready_valid_lane #(
   parameter int SlotW = 8,
   parameter int CntW  = 3
) (
   input  logic             clock,
   input  logic             resetN,
   input  logic             i_lock,   // resync ack to the wires, ignore traffic
   input  logic             i_push,   // word pushed: release final ack, restart
   input  logic [1:0]       i_sync,   // synchronized lane wires
   input  logic [1:0]       i_q,      // synchronized lane wires, one cycle older
   output logic             o_ack,
   output logic             o_done,   // final slot captured, waiting for push
   output logic [SlotW-1:0] o_bits
);

   localparam logic [CntW-1:0] LAST = CntW'(SlotW - 1);

   logic [CntW-1:0]  r_cnt;
   logic             r_done;
   logic             r_ack;
   logic [SlotW-1:0] r_bits;

   logic w_pending;
   logic w_bit;

   // A new bit is pending whenever the wire parity differs from our ack. A
   // pending bit is seen in the same cycle its wire changed, because every
   // earlier bit was acked at once. That lets the changed wire be found by
   // comparing against the one-cycle-older copy.
   assign w_pending = r_ack != ^i_sync;
   assign w_bit     = i_q[1] ^ i_sync[1];

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_cnt  <= '0;
         r_done <= 1'b0;
         r_ack  <= 1'b0;
         r_bits <= '0;
      end else if (i_lock) begin
         // Traffic left pending from before reset must not look like a new bit.
         r_ack <= ^i_sync;
      end else if (i_push) begin
         r_ack  <= ~r_ack;
         r_cnt  <= '0;
         r_done <= 1'b0;
      end else if (w_pending && !r_done) begin
         r_bits[r_cnt] <= w_bit;
         if (r_cnt == LAST) begin
            r_done <= 1'b1;
         end else begin
            r_cnt <= r_cnt + 1'b1;
            r_ack <= ~r_ack;
         end
      end
   end

   assign o_ack  = r_ack;
   assign o_done = r_done;
   assign o_bits = r_bits;

endmodule

module oclib_async_serial_lanes_to_ready_valid #(
   parameter int Width      = 8,
   parameter int Lanes      = 1,
   parameter int Depth      = 2,
   parameter int SyncCycles = 3,
   parameter bit MsbFirst   = 1'b0
) (
   input  logic                       clock,
   input  logic                       resetN,
   input  logic [2*Lanes-1:0]         inData,
   output logic [Lanes-1:0]           inAck,
   output logic [Width-1:0]           outData,
   output logic                       outValid,
   input  logic                       outReady,
   output logic [$clog2(Depth+1)-1:0] outCount
);

   localparam int SlotW  = Width / Lanes;
   localparam int SCntW  = (SlotW > 1) ? $clog2(SlotW) : 1;
   localparam int PtrW   = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int CountW = $clog2(Depth + 1);

   typedef enum logic {LOCK, RUN} state_t;

   // ---------------------------------------------------------------- sync
   // The synchronizer and the delayed copy are not reset. They only track
   // the wires, and the LOCK cycle after reset absorbs whatever they hold.
   logic [SyncCycles-1:0][2*Lanes-1:0] r_sync;
   logic [2*Lanes-1:0]                 r_inDataQ;
   logic [2*Lanes-1:0]                 w_inDataSync;

   always_ff @(posedge clock) begin
      r_sync[0] <= inData;
      for (int i = 1; i < SyncCycles; i++) r_sync[i] <= r_sync[i-1];
      r_inDataQ <= w_inDataSync;
   end

   assign w_inDataSync = r_sync[SyncCycles-1];

   // ----------------------------------------------------------------- fsm
   state_t r_state;
   logic   w_lock;

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) r_state <= LOCK;
      else         r_state <= RUN;
   end

   assign w_lock = r_state == LOCK;

   // --------------------------------------------------------------- lanes
   logic [Lanes-1:0]            w_done;
   logic [Lanes-1:0][SlotW-1:0] w_bits;
   logic [Width-1:0]            w_word;
   logic                        w_push;
   logic                        w_pop;

   for (genvar l = 0; l < Lanes; l++) begin : g_lane
      oclib_async_serial_lanes_to_ready_valid_lane #(
         .SlotW (SlotW),
         .CntW  (SCntW)
      ) u_lane (
         .clock  (clock),
         .resetN (resetN),
         .i_lock (w_lock),
         .i_push (w_push),
         .i_sync (w_inDataSync[2*l +: 2]),
         .i_q    (r_inDataQ[2*l +: 2]),
         .o_ack  (inAck[l]),
         .o_done (w_done[l]),
         .o_bits (w_bits[l])
      );
      // Scatter the lane's slots into the word.
      for (genvar k = 0; k < SlotW; k++) begin : g_slot
         localparam int Idx = l + k * Lanes;
         localparam int Pos = MsbFirst ? (Width - 1 - Idx) : Idx;
         assign w_word[Pos] = w_bits[l][k];
      end
   end

   // ---------------------------------------------------------------- fifo
   // Free space is judged on the registered count alone. A pop in the same
   // cycle therefore never makes room for a push into a full FIFO.
   logic [Width-1:0]  r_mem [Depth];
   logic [PtrW-1:0]   r_wr;
   logic [PtrW-1:0]   r_rd;
   logic [CountW-1:0] r_count;

   function automatic logic [PtrW-1:0] f_next(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign w_push = (&w_done) && (r_count < CountW'(Depth));
   assign w_pop  = outValid && outReady;

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
         for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= w_word;
            r_wr        <= f_next(r_wr);
         end
         if (w_pop) r_rd <= f_next(r_rd);
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      end
   end

   assign outData  = r_mem[r_rd];
   assign outValid = r_count != '0;
   assign outCount = r_count;

endmodule

// File: tb/tb_oclib_async_serial_lanes_to_ready_valid.sv
module tb_oclib_async_serial_lanes_to_ready_valid;

   localparam int W = 8;
   localparam int D = 2;

   logic clock = 1'b0;
   logic resetN;
   always #5 clock = ~clock;

   // dut2: 2 lanes, MSB first (main, randomized + scoreboard)
   logic [1:0] ln0, ln1;
   logic [3:0] in2;
   logic [1:0] ack2;
   logic [W-1:0] data2;
   logic valid2, ready2;
   logic [1:0] count2;
   assign in2 = {ln1, ln0};

   // dut1: 1 lane, LSB first (directed)
   logic [1:0] lna;
   logic [0:0] ack1;
   logic [W-1:0] data1;
   logic valid1, ready1;
   logic [1:0] count1;

   oclib_async_serial_lanes_to_ready_valid #(
      .Width(W), .Lanes(2), .Depth(D), .SyncCycles(3), .MsbFirst(1'b1)
   ) dut2 (
      .clock(clock), .resetN(resetN), .inData(in2), .inAck(ack2),
      .outData(data2), .outValid(valid2), .outReady(ready2), .outCount(count2)
   );

   oclib_async_serial_lanes_to_ready_valid #(
      .Width(W), .Lanes(1), .Depth(D), .SyncCycles(3), .MsbFirst(1'b0)
   ) dut1 (
      .clock(clock), .resetN(resetN), .inData(lna), .inAck(ack1),
      .outData(data1), .outValid(valid1), .outReady(ready1), .outCount(count1)
   );

   int checks = 0;
   int errors = 0;
   logic [W-1:0] expq[$];   // words in send order = required output order
   bit mon_en = 1'b0;
   bit rnd_done;

   // Which word bit lane l carries in slot k.
   function automatic logic slot_bit(input logic [7:0] w, input int lanes,
                                     input bit msb, input int l, input int k);
      int idx;
      idx = l + k * lanes;
      return msb ? w[7-idx] : w[idx];
   endfunction

   function automatic logic lane_par(input int l);
      return (l == 0) ? ^ln0 : ^ln1;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_ack2(input int l);
      int n;
      n = 0;
      checks++;
      do begin @(negedge clock); n++; end
      while (ack2[l] != lane_par(l) && n < 2000);
      if (ack2[l] != lane_par(l)) begin
         errors++;
         $display("FAIL ack_wait2 lane %0d: inAck=%0b required %0b", l, ack2[l], lane_par(l));
      end
   endtask

   task automatic wait_ack1();
      int n;
      n = 0;
      checks++;
      do begin @(negedge clock); n++; end
      while (ack1[0] != ^lna && n < 2000);
      if (ack1[0] != ^lna) begin
         errors++;
         $display("FAIL ack_wait1: inAck=%0b required %0b", ack1[0], ^lna);
      end
   endtask

   task automatic send_lane(input int l, input logic [7:0] w, input int skew,
                            input int gapmax, input int nslots);
      int b;
      repeat (skew) tick();
      for (int k = 0; k < nslots; k++) begin
         b = int'(slot_bit(w, 2, 1'b1, l, k));
         if (l == 0) ln0[b] = ~ln0[b];
         else        ln1[b] = ~ln1[b];
         wait_ack2(l);
         tick();
         repeat ($urandom_range(0, gapmax)) tick();
      end
   endtask

   task automatic send_word(input logic [7:0] w, input int s0, input int s1, input int gap);
      fork
         send_lane(0, w, s0, gap, 4);
         send_lane(1, w, s1, gap, 4);
      join
   endtask

   // One compare process for dut2 against the word-order model.
   task automatic monitor();
      logic pv, pr;
      logic [W-1:0] pd, e;
      pv = 1'b0; pr = 1'b0; pd = '0;
      forever begin
         @(negedge clock);
         if (!mon_en) begin
            pv = 1'b0;
         end else begin
            checks++;
            if (count2 > 2'(D) || valid2 != (count2 != 0)) begin
               errors++;
               $display("FAIL status: valid=%0b count=%0d, required valid==(count!=0), count<=%0d",
                        valid2, count2, D);
            end
            if (pv && !pr) begin
               checks++;
               if (!valid2 || data2 != pd) begin
                  errors++;
                  $display("FAIL hold: valid=%0b data=0x%0h required valid=1 data=0x%0h",
                           valid2, data2, pd);
               end
            end
            if (valid2 && ready2) begin
               checks++;
               if (expq.size() == 0) begin
                  errors++;
                  $display("FAIL order: got unexpected word 0x%0h, required none", data2);
               end else begin
                  e = expq.pop_front();
                  if (data2 != e) begin
                     errors++;
                     $display("FAIL order: got 0x%0h required 0x%0h", data2, e);
                  end
               end
            end
            pv = valid2; pr = ready2; pd = data2;
         end
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] wa;
      int n;
      resetN = 1'b0;
      ln0 = '0; ln1 = '0; lna = '0;
      ready1 = 1'b0; ready2 = 1'b0;
      fork monitor(); join_none
      repeat (3) tick();

      // Reset state
      chk("rst_valid2", 32'(valid2), 0);
      chk("rst_count2", 32'(count2), 0);
      chk("rst_data2",  32'(data2),  0);
      chk("rst_ack2",   32'(ack2),   0);
      chk("rst_valid1", 32'(valid1), 0);
      chk("rst_data1",  32'(data1),  0);

      resetN = 1'b1;
      repeat (6) tick();
      mon_en = 1'b1;

      // Single lane, LSB first, 0xA5
      ready1 = 1'b1;
      wa = 8'hA5;
      for (int k = 0; k < 8; k++) begin
         lna[wa[k]] = ~lna[wa[k]];
         wait_ack1();
         if (k == 7) begin
            chk("a5_valid", 32'(valid1), 1);
            chk("a5_data",  32'(data1),  32'hA5);
         end
         tick();
      end
      n = 0;
      repeat (10) begin @(negedge clock); if (valid1) n++; end
      chk("a5_one_cycle", 32'(n), 0);

      // Two lanes, MSB first, 0x3C with lane 1 skewed by 5 cycles
      ready2 = 1'b1;
      expq.push_back(8'h3C);
      fork
         send_lane(0, 8'h3C, 0, 0, 4);
         send_lane(1, 8'h3C, 5, 0, 4);
         begin
            n = 0;
            repeat (20) begin @(negedge clock); if (valid2 || count2 != 0) n++; end
            chk("skew_no_early_push", 32'(n), 0);
         end
      join
      repeat (10) tick();
      chk("skew_drained", 32'(expq.size()), 0);

      // Backpressure: 3 words into a 2-deep FIFO, then a single pop
      ready2 = 1'b0;
      expq.push_back(8'h5A); expq.push_back(8'hC3); expq.push_back(8'h96);
      send_word(8'h5A, 0, 1, 1);
      send_word(8'hC3, 2, 0, 1);
      fork
         send_word(8'h96, 0, 3, 0);
         begin
            repeat (60) tick();
            chk("full_count", 32'(count2), 2);
            chk("full_head", 32'(data2), 32'h5A);
            chk("withheld_ack0", 32'(ack2[0] == lane_par(0)), 0);
            chk("withheld_ack1", 32'(ack2[1] == lane_par(1)), 0);
            ready2 = 1'b1;
            tick();
            chk("pop_no_push", 32'(count2), 1);
            ready2 = 1'b0;
            tick();
            chk("push_next", 32'(count2), 2);
            chk("released_ack0", 32'(ack2[0] == lane_par(0)), 1);
            chk("released_ack1", 32'(ack2[1] == lane_par(1)), 1);
            ready2 = 1'b1;
            repeat (10) tick();
            chk("bp_empty", 32'(count2), 0);
         end
      join
      chk("bp_drained", 32'(expq.size()), 0);

      // Randomized words, skew, gaps and backpressure
      rnd_done = 1'b0;
      fork
         begin
            logic [7:0] w;
            for (int i = 0; i < 30; i++) begin
               w = 8'($urandom);
               expq.push_back(w);
               send_word(w, $urandom_range(0, 6), $urandom_range(0, 6), 3);
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               ready2 = ($urandom_range(0, 3) != 0);
               tick();
            end
            ready2 = 1'b1;
         end
      join
      repeat (20) tick();
      chk("rand_drained", 32'(expq.size()), 0);

      // Reset mid-word with a word stored in the FIFO
      ready2 = 1'b0;
      expq.push_back(8'h77);
      send_word(8'h77, 0, 0, 0);
      repeat (2) tick();
      chk("stored_valid", 32'(valid2), 1);
      fork
         send_lane(0, 8'h12, 0, 0, 2);
         send_lane(1, 8'h12, 0, 0, 2);
      join
      mon_en = 1'b0;
      resetN = 1'b0;
      #1;
      chk("midrst_valid", 32'(valid2), 0);
      chk("midrst_count", 32'(count2), 0);
      expq.delete();
      repeat (3) tick();
      resetN = 1'b1;
      repeat (6) tick();
      mon_en = 1'b1;
      ready2 = 1'b1;
      expq.push_back(8'hFF);
      send_word(8'hFF, 0, 2, 1);
      repeat (10) tick();
      chk("ff_drained", 32'(expq.size()), 0);

      // Stale toggle held across reset must be absorbed by LOCK
      mon_en = 1'b0;
      resetN = 1'b0;
      tick();
      ln0[0] = ~ln0[0];
      repeat (3) tick();
      resetN = 1'b1;
      repeat (8) tick();
      chk("lock_valid", 32'(valid2), 0);
      chk("lock_count", 32'(count2), 0);
      chk("lock_ack0", 32'(ack2[0]), 32'(^ln0));
      chk("lock_ack1", 32'(ack2[1]), 32'(^ln1));
      mon_en = 1'b1;
      expq.push_back(8'hA3);
      send_word(8'hA3, 1, 0, 2);
      repeat (10) tick();
      chk("lock_drained", 32'(expq.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/oclib_async_serial_lanes_to_ready_valid.md
OCLIB_ASYNC_SERIAL_LANES_TO_READY_VALID -- requirements
Module: oclib_async_serial_lanes_to_ready_valid

Interface
REQ-001 SHALL have parameter Width, default 8: output word width in bits; Width SHALL be an integer multiple of Lanes.
REQ-002 SHALL have parameter Lanes, default 1: number of independent 2-wire serial lanes.
REQ-003 SHALL have parameter Depth, default 2: output FIFO depth in words; power of 2, at least 1.
REQ-004 SHALL have parameter SyncCycles, default 3: synchronizer flops per async input bit.
REQ-005 SHALL have parameter MsbFirst, default 0: 0 sends word bits LSB-first per lane; 1 sends them MSB-first.
REQ-006 SHALL have port clock, input, 1 bit: the single clock.
REQ-007 SHALL have port resetN, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port inData, input, 2*Lanes bits, async: lane l uses bits [2l+1:2l]; toggling [2l] sends a 0, toggling [2l+1] sends a 1.
REQ-009 SHALL have port inAck, output, Lanes bits: bit l equals ^inData[2l+1:2l] once lane l's bit is consumed.
REQ-010 SHALL have port outData, output, Width bits: FIFO head word.
REQ-011 SHALL have port outValid, output, 1 bit: FIFO non-empty.
REQ-012 SHALL have port outReady, input, 1 bit: consumer accepts the head word when outValid is high.
REQ-013 SHALL have port outCount, output, $clog2(Depth+1) bits: FIFO occupancy.

Function
REQ-014 SHALL pass all 2*Lanes inData bits through a SyncCycles-stage synchronizer (inDataSync) before any use, and register inDataSync each cycle as inDataQ.
REQ-015 SHALL implement a top FSM with states LOCK and RUN; it enters LOCK on reset, moves LOCK->RUN after exactly one clock, and has no other transitions.
REQ-016 In LOCK, for every lane l, SHALL load inAck[l] <= ^inDataSync[l] so that traffic already pending upstream is not seen as a new bit.
REQ-017 In RUN, a lane SHALL see a bit as pending when inAck[l] != ^inDataSync[l]; the bit value SHALL be inDataQ[l][1]^inDataSync[l][1].
REQ-018 Each lane SHALL keep a counter 0..Width/Lanes-1, one slot per bit.
REQ-019 Lane l slot k SHALL map to word bit l+k*Lanes when MsbFirst=0, and to Width-1-(l+k*Lanes) when MsbFirst=1.
REQ-020 A pending bit in a non-final slot SHALL be written to the assembly register, the lane counter incremented, and inAck[l] toggled, all in the same cycle, independent of other lanes and of FIFO state.
REQ-021 A pending bit in the final slot SHALL be written to the assembly register and held, with inAck[l] not toggled and the counter not advanced; lane l then sits in a lane-done state.
REQ-022 A push SHALL occur in the cycle all Lanes are lane-done and outCount < Depth; in that cycle every final-slot inAck SHALL toggle and all lane counters SHALL clear to 0.
REQ-023 A push SHALL NOT occur while outCount == Depth, even if a pop occurs in the same cycle; the push then happens the next cycle (no full pass-through).
REQ-024 A pop SHALL occur when outValid && outReady.
REQ-025 Simultaneous push and pop with 0 < outCount < Depth SHALL leave outCount unchanged.
REQ-026 A pushed word SHALL reach outData/outValid exactly one cycle after the push cycle.
REQ-027 outData SHALL hold stable while outValid && !outReady.
REQ-028 FIFO pointers SHALL wrap modulo Depth.
REQ-029 Backpressure SHALL reach upstream only by withholding final-slot acks; overflow SHALL be impossible.
REQ-030 Best-case throughput SHALL be one bit per lane per cycle after sync latency.

Reset
REQ-031 On resetN low, asynchronously: outValid=0, outCount=0, outData=0, inAck=0, lane counters=0, assembly register=0, FIFO pointers=0, FSM=LOCK.
REQ-032 Synchronizer and inDataQ flops SHALL NOT be reset.
REQ-033 resetN asserted mid-word or mid-FIFO SHALL discard all partial and stored words; after release the LOCK cycle SHALL resync inAck to the current inData.

Verification
REQ-034 Width=8, Lanes=1, MsbFirst=0, send 0xA5 as 8 toggles with outReady=1 -> outData=0xA5, outValid high for one cycle; inAck matches ^inData after every bit.
REQ-035 Width=8, Lanes=2, MsbFirst=1, send 0x3C with lanes skewed by 5 cycles -> single word 0x3C; no push until the slower lane completes.
REQ-036 Depth=2, outReady=0, send 3 words -> outCount=2; third word's final-slot acks withheld; raising outReady -> all 3 words in order, third pushed one cycle after count < 2.
REQ-037 Full FIFO, pop and a complete word in the same cycle -> no push that cycle; push next cycle; outCount 2->1->2.
REQ-038 Hold inData[0] toggled (inAck stale) across resetN pulse -> after LOCK, no spurious bit captured; next sent word decodes correctly.
REQ-039 Assert resetN mid-word (4 of 8 bits) -> outValid=0, outCount=0 immediately; subsequent full word 0xFF decodes correctly.
